swap_unit: RTL and testbench
============================

Name: swap_unit

Overview:
- Parametrised successor to the 16-bit operand swap block.
- Latches two operands through a valid/ready handshake and applies one of four modes: pass, swap, sort ascending, sort descending.
- Exchanges operands with a three-cycle XOR-swap sequence, so no temporary register is needed.
- Sits beside the ALU in the datapath, serving register-exchange and compare-exchange micro-ops.

Parameters:
- WIDTH, 16, operand width in bits.
- SIGNED, 0, 1 = sort modes compare as two's complement; 0 = unsigned.
- CNT_W, 8, width of the exchange statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  unit can accept an operation.
- mode  in  2  00 PASS, 01 SWAP, 10 SORT_ASC, 11 SORT_DESC.
- operand_a  in  WIDTH  first operand.
- operand_b  in  WIDTH  second operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result_a  out  WIDTH  first result.
- result_b  out  WIDTH  second result.
- swapped  out  1  result is exchanged relative to input.
- swap_count  out  CNT_W  completed exchanges (SWAP_STATS_EN only).

Behaviour:
- Reset (asynchronous, any state, including mid-sequence):
  - State goes to IDLE.
  - ra, rb, swapped, swap_count clear to 0.
  - out_valid = 0, in_ready = 1, result_a = result_b = 0.
  - Any operation in flight is discarded.
- States: IDLE, CMP, XOR1, XOR2, XOR3, DONE.
- in_ready = (state == IDLE).
- out_valid = (state == DONE).
- result_a = ra, result_b = rb in all states; contents are meaningful only while out_valid = 1.
- Accept: in_valid && in_ready on an edge latches ra <= operand_a, rb <= operand_b, mode, and clears swapped. Next state:
  - PASS -> DONE.
  - SWAP -> XOR1.
  - SORT_* -> CMP.
- CMP (one cycle):
  - SORT_ASC goes to XOR1 if ra > rb, else DONE.
  - SORT_DESC goes to XOR1 if ra < rb, else DONE.
  - Equal operands never exchange.
  - The comparison honours SIGNED.
- XOR sequence:
  - XOR1: ra <= ra ^ rb.
  - XOR2: rb <= ra ^ rb.
  - XOR3: ra <= ra ^ rb, swapped <= 1, then go to DONE.
  - SWAP mode with equal operands still runs the full sequence and ends with swapped = 1.
- Latency, accept edge to first out_valid cycle:
  - PASS: 1 cycle.
  - SWAP: 4 cycles.
  - SORT without exchange: 2 cycles.
  - SORT with exchange: 5 cycles.
- DONE:
  - Holds result_a, result_b and swapped stable while out_ready = 0.
  - out_valid && out_ready -> IDLE.
  - No new operation is accepted in the same cycle as result consumption; back-to-back throughput is latency + 1.
- in_valid is ignored outside IDLE, and operand changes outside IDLE have no effect.
- X-free outputs are required after reset.

Optional Feature:
- Macro SWAP_STATS_EN.
- Defined:
  - swap_count increments by 1 on each XOR3 cycle.
  - It wraps modulo 2^CNT_W and clears on rst.
- Undefined:
  - The swap_count port and counter are not present.
  - All other behaviour is identical.

Decomposition:
- Shared package swap_pkg holds:
  - mode encodings MODE_PASS/MODE_SWAP/MODE_SORT_ASC/MODE_SORT_DESC.
  - The state enum.
- One sub-module, swap_cmp:
  - Parametrised by WIDTH and SIGNED.
  - Outputs gt and lt for two operands.
  - Purely combinational, instantiated once for the CMP decision.

Test Plan:
- Reset, then SWAP with a=99, b=64 and out_ready=1 -> out_valid 4 cycles after accept; result_a=64, result_b=99, swapped=1.
- PASS with a=99, b=64 -> out_valid 1 cycle after accept; results 99/64, swapped=0.
- SORT_ASC with 99/64 -> 64/99, latency 5, swapped=1.
- SORT_ASC with 64/99 -> 64/99, latency 2, swapped=0.
- SORT_ASC with equal operands 5/5 -> 5/5, swapped=0.
- SORT_ASC with a=16'hFFFF, b=16'h0001:
  - SIGNED=0 -> exchange, giving 0001/FFFF.
  - SIGNED=1 -> no exchange, giving FFFF/0001.
- Backpressure: out_ready=0 for 10 cycles after DONE -> out_valid stays 1, results stable, in_ready=0, in_valid pulses ignored; raising out_ready returns to IDLE next edge.
- Reset asserted during XOR2 of a SWAP -> immediate IDLE, outputs 0; with SWAP_STATS_EN, swap_count stays 0. Separately, 256 swaps with CNT_W=8 -> swap_count wraps to 0.

Source files
------------

// File: rtl/swap_pkg.sv
// ----------------------------------------------------------------------------
// swap_pkg
// Shared definitions for the operand swap unit:
//   - 2-bit mode encodings presented on swap_unit.mode
//   - the sequencing state enum used by swap_unit
// ----------------------------------------------------------------------------
package swap_pkg;

    localparam logic [1:0] MODE_PASS      = 2'b00;
    localparam logic [1:0] MODE_SWAP      = 2'b01;
    localparam logic [1:0] MODE_SORT_ASC  = 2'b10;
    localparam logic [1:0] MODE_SORT_DESC = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMP  = 3'd1,
        S_XOR1 = 3'd2,
        S_XOR2 = 3'd3,
        S_XOR3 = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/swap_cmp.sv
// ----------------------------------------------------------------------------
// swap_cmp
// Purely combinational magnitude comparator for the sort decision.
// Parameters:
//   WIDTH  - operand width
//   SIGNED - 1: two's complement compare, 0: unsigned compare
// Ports:
//   a_i, b_i  in   operands
//   gt_o      out  a_i > b_i
//   lt_o      out  a_i < b_i
// ----------------------------------------------------------------------------
module swap_cmp #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);

    always_comb begin
        if (SIGNED) begin
            gt_o = ($signed(a_i) > $signed(b_i));
            lt_o = ($signed(a_i) < $signed(b_i));
        end else begin
            gt_o = (a_i > b_i);
            lt_o = (a_i < b_i);
        end
    end

endmodule

// File: rtl/swap_unit.sv
// ----------------------------------------------------------------------------
// swap_unit
// Latches two operands through a valid/ready handshake and applies PASS,
// SWAP, SORT_ASC or SORT_DESC. Exchanges use a three-cycle XOR swap, so no
// temporary register is needed.
//
// Optional feature: define SWAP_STATS_EN to add the swap_count port, a
// CNT_W-bit wrapping counter of completed exchanges.
//
// Parameters: WIDTH (operand width), SIGNED (sort compare signedness),
//             CNT_W (statistics counter width)
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operation handshake (ready only in IDLE)
//   mode                 operation select (see swap_pkg)
//   operand_a/operand_b  operands
//   out_valid/out_ready  result handshake (valid only in DONE)
//   result_a/result_b    working registers, meaningful while out_valid
//   swapped              result is exchanged relative to the input
//   swap_count           exchanges completed (SWAP_STATS_EN only)
// ----------------------------------------------------------------------------
module swap_unit
    import swap_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter bit          SIGNED = 1'b0,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_a,
    output logic [WIDTH-1:0] result_b,
    output logic             swapped
`ifdef SWAP_STATS_EN
    ,
    output logic [CNT_W-1:0] swap_count
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("swap_unit: CNT_W must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [1:0]       mode_q, mode_d;
    logic             swapped_q, swapped_d;
    logic             a_gt_b, a_lt_b;

    swap_cmp #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a_i  (ra_q),
        .b_i  (rb_q),
        .gt_o (a_gt_b),
        .lt_o (a_lt_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ra_q      <= '0;
            rb_q      <= '0;
            mode_q    <= MODE_PASS;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            mode_q    <= mode_d;
            swapped_q <= swapped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        mode_d    = mode_q;
        swapped_d = swapped_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ra_d      = operand_a;
                    rb_d      = operand_b;
                    mode_d    = mode;
                    swapped_d = 1'b0;
                    case (mode)
                        MODE_PASS: state_d = S_DONE;
                        MODE_SWAP: state_d = S_XOR1;
                        default:   state_d = S_CMP;
                    endcase
                end
            end
            S_CMP: begin
                // Only sort modes reach CMP; equal operands never exchange.
                if ((mode_q == MODE_SORT_ASC  && a_gt_b) ||
                    (mode_q == MODE_SORT_DESC && a_lt_b)) begin
                    state_d = S_XOR1;
                end else begin
                    state_d = S_DONE;
                end
            end
            // a^=b; b^=a; a^=b -- exchange without a temporary register.
            S_XOR1: begin
                ra_d    = ra_q ^ rb_q;
                state_d = S_XOR2;
            end
            S_XOR2: begin
                rb_d    = ra_q ^ rb_q;
                state_d = S_XOR3;
            end
            S_XOR3: begin
                ra_d      = ra_q ^ rb_q;
                swapped_d = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result_a  = ra_q;
    assign result_b  = rb_q;
    assign swapped   = swapped_q;

`ifdef SWAP_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == S_XOR3) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign swap_count = cnt_q;
`endif

endmodule

// File: tb/tb_swap_unit.sv
module tb_swap_unit;
    import swap_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [1:0]   mode;
    logic [W-1:0] operand_a, operand_b;
    logic         out_valid, out_ready;
    logic [W-1:0] result_a, result_b;
    logic         swapped;
    logic         in_valid_s, in_ready_s, out_valid_s, swapped_s;
    logic [W-1:0] result_a_s, result_b_s;
`ifdef SWAP_STATS_EN
    logic [7:0]   swap_count, swap_count_s;
`endif

    always #5 clk = ~clk;

    swap_unit #(.WIDTH(W), .SIGNED(1'b0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_a(result_a), .result_b(result_b), .swapped(swapped)
`ifdef SWAP_STATS_EN
        , .swap_count(swap_count)
`endif
    );

    swap_unit #(.WIDTH(W), .SIGNED(1'b1), .CNT_W(8)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .mode(mode), .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid_s), .out_ready(1'b1),
        .result_a(result_a_s), .result_b(result_b_s), .swapped(swapped_s)
`ifdef SWAP_STATS_EN
        , .swap_count(swap_count_s)
`endif
    );

    typedef struct {
        logic [1:0]   md;
        logic [W-1:0] a, b, ea, eb;
        logic         esw;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] ea, eb;
        logic         esw;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[12];
    vec_t v;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   first_cyc = 0;
    int   model_cnt = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares each consumed result with the queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !prev_ov) first_cyc = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h/%0h with no operation pending",
                             result_a, result_b);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result_a", 32'(result_a), 32'(mon_e.ea));
                    chk("result_b", 32'(result_b), 32'(mon_e.eb));
                    chk("swapped", 32'(swapped), 32'(mon_e.esw));
                    chk("latency", 32'(first_cyc - mon_e.acc + 1), 32'(mon_e.lat));
`ifdef SWAP_STATS_EN
                    if (mon_e.esw) model_cnt++;
                    chk("swap_count", 32'(swap_count), 32'(model_cnt % 256));
`endif
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic do_op(input vec_t t_v);
        int t = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        mode      = t_v.md;
        operand_a = t_v.a;
        operand_b = t_v.b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        e.ea = t_v.ea; e.eb = t_v.eb; e.esw = t_v.esw; e.lat = t_v.lat; e.acc = cyc;
        sb.push_back(e);
        in_valid  = 1'b0;
        operand_a = W'($urandom);
        operand_b = W'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic do_s(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ea, input logic [W-1:0] eb, input logic esw,
                        input int lat);
        int t;
        @(negedge clk);
        chk("s_in_ready", 32'(in_ready_s), 32'd1);
        mode = md; operand_a = a; operand_b = b; in_valid_s = 1'b1;
        @(posedge clk);
        #1;
        in_valid_s = 1'b0;
        t = 1;
        while (!out_valid_s && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("s_result_a", 32'(result_a_s), 32'(ea));
        chk("s_result_b", 32'(result_b_s), 32'(eb));
        chk("s_swapped", 32'(swapped_s), 32'(esw));
        chk("s_latency", 32'(t), 32'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{MODE_SWAP,      16'd99,     16'd64,     16'd64,     16'd99,     1'b1, 4};
        vecs[1]  = '{MODE_PASS,      16'd99,     16'd64,     16'd99,     16'd64,     1'b0, 1};
        vecs[2]  = '{MODE_SORT_ASC,  16'd99,     16'd64,     16'd64,     16'd99,     1'b1, 5};
        vecs[3]  = '{MODE_SORT_ASC,  16'd64,     16'd99,     16'd64,     16'd99,     1'b0, 2};
        vecs[4]  = '{MODE_SORT_ASC,  16'd5,      16'd5,      16'd5,      16'd5,      1'b0, 2};
        vecs[5]  = '{MODE_SORT_ASC,  16'hFFFF,   16'h0001,   16'h0001,   16'hFFFF,   1'b1, 5};
        vecs[6]  = '{MODE_SORT_DESC, 16'd64,     16'd99,     16'd99,     16'd64,     1'b1, 5};
        vecs[7]  = '{MODE_SORT_DESC, 16'd99,     16'd64,     16'd99,     16'd64,     1'b0, 2};
        vecs[8]  = '{MODE_SORT_DESC, 16'd7,      16'd7,      16'd7,      16'd7,      1'b0, 2};
        vecs[9]  = '{MODE_SWAP,      16'd5,      16'd5,      16'd5,      16'd5,      1'b1, 4};
        vecs[10] = '{MODE_PASS,      16'h0000,   16'hFFFF,   16'h0000,   16'hFFFF,   1'b0, 1};
        vecs[11] = '{MODE_SORT_DESC, 16'h8000,   16'h7FFF,   16'h8000,   16'h7FFF,   1'b0, 2};

        rst = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0; out_ready = 1'b1;
        mode = MODE_PASS; operand_a = '0; operand_b = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result_a", 32'(result_a), 32'd0);
        chk("rst_result_b", 32'(result_b), 32'd0);
        chk("rst_swapped", 32'(swapped), 32'd0);
`ifdef SWAP_STATS_EN
        chk("rst_swap_count", 32'(swap_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Table-driven operations through the scoreboard.
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i]);
            drain();
        end

        // Signedness of the sort compare (SIGNED=1 instance).
        do_s(MODE_SORT_ASC,  16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 2);
        do_s(MODE_SORT_DESC, 16'hFFFF, 16'h0001, 16'h0001, 16'hFFFF, 1'b1, 5);
        do_s(MODE_SORT_ASC,  16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0, 2);
        do_s(MODE_SORT_ASC,  16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 1'b1, 5);

        // Backpressure: result held while out_ready low; in_valid ignored.
        out_ready = 1'b0;
        v = '{MODE_SORT_ASC, 16'd99, 16'd64, 16'd64, 16'd99, 1'b1, 5};
        do_op(v);
        begin
            int t = 0;
            while (!out_valid && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result_a", 32'(result_a), 32'd64);
            chk("bp_result_b", 32'(result_b), 32'd99);
            chk("bp_swapped", 32'(swapped), 32'd1);
            in_valid  = i[0];
            mode      = MODE_PASS;
            operand_a = 16'h1234;
            operand_b = 16'h5678;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Asynchronous reset while a SWAP is in XOR2.
        @(negedge clk);
        mode = MODE_SWAP; operand_a = 16'd99; operand_b = 16'd64; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_cnt = 0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_result_a", 32'(result_a), 32'd0);
        chk("midrst_result_b", 32'(result_b), 32'd0);
        chk("midrst_swapped", 32'(swapped), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_idle_out_valid", 32'(out_valid), 32'd0);
`ifdef SWAP_STATS_EN
            chk("midrst_swap_count", 32'(swap_count), 32'd0);
`endif
        end

        // 256 exchanges: the 8-bit counter wraps back to zero.
        for (int i = 0; i < 256; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            v = '{MODE_SWAP, ra, rb, rb, ra, 1'b1, 4};
            do_op(v);
        end
        drain();
`ifdef SWAP_STATS_EN
        chk("wrap_swap_count", 32'(swap_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
